// File: rtl/axis_img_pkg.sv
// Shared image-stream definitions: byte phase encoding, default frame geometry
// and the pixel payload carried through the output register slice.
package axis_img_pkg;

  typedef enum logic [1:0] {
    PH_R = 2'd0,
    PH_G = 2'd1,
    PH_B = 2'd2
  } phase_e;

  localparam int IMG_WIDTH   = 224;
  localparam int IMG_HEIGHT  = 224;
  localparam int TOTAL_BYTES = IMG_WIDTH * IMG_HEIGHT * 3;

  typedef struct packed {
    logic [23:0] rgb;
    logic [7:0]  x;
    logic [7:0]  y;
    logic        last;
  } pix_t;

  function automatic int frame_bytes(input int w, input int h);
    return w * h * 3;
  endfunction

endpackage

// File: rtl/axis_rgb_collector_if.sv
// Assembled-pixel stream: {R,G,B} payload with raster position and valid/ready.
interface axis_rgb_collector_if;

  logic [23:0] rgb;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        last;
  logic        vld;
  logic        rdy;

  modport master (output rgb, x, y, last, vld, input rdy);
  modport slave  (input rgb, x, y, last, vld, output rdy);

endinterface

// File: rtl/rgb_out_reg.sv
// Single-entry register slice for assembled pixels; one-cycle latency,
// accepts a new load whenever empty or being drained in the same cycle.
module rgb_out_reg
  import axis_img_pkg::*;
(
  input  logic                  hdmi_clk,
  input  logic                  rst_n,
  input  logic                  load_vld,
  input  pix_t                  load_dat,
  output logic                  load_rdy,
  axis_rgb_collector_if.master  pix
);

  pix_t data_q;
  logic vld_q;

  assign load_rdy = !vld_q || pix.rdy;

  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      vld_q  <= 1'b0;
      data_q <= '0;
    end else if (load_vld && load_rdy) begin
      vld_q  <= 1'b1;
      data_q <= load_dat;
    end else if (pix.rdy) begin
      vld_q  <= 1'b0;
    end
  end

  assign pix.vld  = vld_q;
  assign pix.rgb  = data_q.rgb;
  assign pix.x    = data_q.x;
  assign pix.y    = data_q.y;
  assign pix.last = data_q.last;

endmodule

// File: rtl/axis_rgb_collector.sv
// Collects an R,G,B byte stream into 24-bit pixels tagged with raster x/y.
// One cycle from B byte to pix_valid; B byte is held off only while output is full.
module axis_rgb_collector
  import axis_img_pkg::*;
#(
  parameter int WIDTH  = IMG_WIDTH,
  parameter int HEIGHT = IMG_HEIGHT
) (
  input  logic        hdmi_clk,
  input  logic        rst_n,
  input  logic [7:0]  s_axis_0_tdata,
  input  logic        s_axis_0_tvalid,
  output logic        s_axis_0_tready,
  output logic [23:0] pix_rgb,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [7:0]  pix_x,
  output logic [7:0]  pix_y,
  output logic        pix_last,
  output logic        frame_done,
  output logic [17:0] byte_cnt
);

  localparam logic [7:0]  X_MAX   = 8'(WIDTH - 1);
  localparam logic [7:0]  Y_MAX   = 8'(HEIGHT - 1);
  localparam logic [17:0] CNT_MAX = 18'(frame_bytes(WIDTH, HEIGHT) - 1);

  phase_e      phase_q, phase_d;
  logic [7:0]  r_q, g_q, x_q, y_q;
  logic        accept, load_vld, load_rdy;
  pix_t        load_dat;

  axis_rgb_collector_if pix_bus ();

  rgb_out_reg u_out (
    .hdmi_clk (hdmi_clk),
    .rst_n    (rst_n),
    .load_vld (load_vld),
    .load_dat (load_dat),
    .load_rdy (load_rdy),
    .pix      (pix_bus.master)
  );

  assign pix_bus.rdy = pix_ready;
  assign pix_rgb     = pix_bus.rgb;
  assign pix_valid   = pix_bus.vld;
  assign pix_x       = pix_bus.x;
  assign pix_y       = pix_bus.y;
  assign pix_last    = pix_bus.last;

  // Only the B byte needs output space; R and G just land in holding registers.
  assign s_axis_0_tready = rst_n && ((phase_q != PH_B) || load_rdy);
  assign accept          = s_axis_0_tvalid && s_axis_0_tready;
  assign load_vld        = accept && (phase_q == PH_B);
  assign load_dat        = '{rgb:  {r_q, g_q, s_axis_0_tdata},
                             x:    x_q,
                             y:    y_q,
                             last: (x_q == X_MAX) && (y_q == Y_MAX)};

  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) phase_q <= PH_R;
    else        phase_q <= phase_d;
  end

  always_comb begin
    phase_d = phase_q;
    if (accept) begin
      case (phase_q)
        PH_R:    phase_d = PH_G;
        PH_G:    phase_d = PH_B;
        default: phase_d = PH_R;
      endcase
    end
  end

  always_ff @(posedge hdmi_clk) begin
    if (!rst_n) begin
      r_q        <= '0;
      g_q        <= '0;
      x_q        <= '0;
      y_q        <= '0;
      byte_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pix_bus.vld && pix_ready && pix_bus.last;
      if (accept && phase_q == PH_R) r_q <= s_axis_0_tdata;
      if (accept && phase_q == PH_G) g_q <= s_axis_0_tdata;
      if (load_vld) begin
        if (x_q == X_MAX) begin
          x_q <= '0;
          y_q <= (y_q == Y_MAX) ? 8'd0 : y_q + 8'd1;
        end else begin
          x_q <= x_q + 8'd1;
        end
      end
      if (accept) byte_cnt <= (byte_cnt == CNT_MAX) ? 18'd0 : byte_cnt + 18'd1;
    end
  end

endmodule

// File: tb/tb_axis_rgb_collector.sv
// Scoreboard bench: small 4x2 instance for directed/random cases, default
// instance for a full-throughput 224x224 frame.
module tb_axis_rgb_collector;
  import axis_img_pkg::*;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int FB = W * H * 3;

  logic        hdmi_clk = 1'b0;
  logic        rst_n    = 1'b0;
  logic [7:0]  s_tdata  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        frame_done;
  logic [17:0] byte_cnt;

  axis_rgb_collector_if mon_if ();

  axis_rgb_collector #(.WIDTH(W), .HEIGHT(H)) dut (
    .hdmi_clk        (hdmi_clk),
    .rst_n           (rst_n),
    .s_axis_0_tdata  (s_tdata),
    .s_axis_0_tvalid (s_tvalid),
    .s_axis_0_tready (s_tready),
    .pix_rgb         (mon_if.rgb),
    .pix_valid       (mon_if.vld),
    .pix_ready       (mon_if.rdy),
    .pix_x           (mon_if.x),
    .pix_y           (mon_if.y),
    .pix_last        (mon_if.last),
    .frame_done      (frame_done),
    .byte_cnt        (byte_cnt)
  );

  logic        b_rst_n = 1'b0, b_tvalid = 1'b0, b_tready, b_pix_ready = 1'b1;
  logic [7:0]  b_tdata = '0, b_x, b_y;
  logic [23:0] b_rgb;
  logic        b_pix_valid, b_last, b_frame_done;
  logic [17:0] b_byte_cnt;

  axis_rgb_collector big (
    .hdmi_clk        (hdmi_clk),
    .rst_n           (b_rst_n),
    .s_axis_0_tdata  (b_tdata),
    .s_axis_0_tvalid (b_tvalid),
    .s_axis_0_tready (b_tready),
    .pix_rgb         (b_rgb),
    .pix_valid       (b_pix_valid),
    .pix_ready       (b_pix_ready),
    .pix_x           (b_x),
    .pix_y           (b_y),
    .pix_last        (b_last),
    .frame_done      (b_frame_done),
    .byte_cnt        (b_byte_cnt)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  int n_vec = 0, n_fail = 0;
  int model_cnt = 0, pix_n = 0, fd_cnt = 0;
  bit rand_rdy = 0, big_done = 0, exp_fd = 0;
  logic [7:0]  byte_q[$];
  logic [40:0] exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference: every third byte closes a pixel; position follows from its index.
  task automatic model_accept(input logic [7:0] b);
    int px, py;
    byte_q.push_back(b);
    model_cnt = (model_cnt + 1) % FB;
    if (byte_q.size() == 3) begin
      px = pix_n % W;
      py = (pix_n / W) % H;
      exp_q.push_back({byte_q[0], byte_q[1], byte_q[2], 8'(px), 8'(py),
                       1'((px == W - 1) && (py == H - 1))});
      byte_q.delete();
      pix_n++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int waits);
    bit acc = 0;
    waits = 0;
    s_tdata  = b;
    s_tvalid = 1'b1;
    while (!acc) begin
      if (rand_rdy) mon_if.rdy = 1'($urandom_range(0, 1));
      #1 acc = s_tready;
      @(posedge hdmi_clk);
      #1;
      if (acc) model_accept(b);
      @(negedge hdmi_clk);
      if (!acc) begin
        waits++;
        if (waits > 200) begin
          n_vec++;
          n_fail++;
          $display("FAIL send_timeout: byte %0h not accepted after %0d cycles, required acceptance", b, waits);
          break;
        end
      end
    end
    s_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    repeat (n) begin
      if (rand_rdy) mon_if.rdy = 1'($urandom_range(0, 1));
      @(negedge hdmi_clk);
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    repeat (2) @(posedge hdmi_clk);
    #1;
    chk("rst_pix_valid", mon_if.vld, 0);
    chk("rst_pix_rgb", mon_if.rgb, 0);
    chk("rst_byte_cnt", byte_cnt, 0);
    chk("rst_tready_low", s_tready, 0);
    chk("rst_frame_done", frame_done, 0);
    byte_q.delete();
    exp_q.delete();
    model_cnt = 0;
    pix_n     = 0;
    fd_cnt    = 0;
    @(negedge hdmi_clk);
    rst_n = 1'b1;
    #1 chk("tready_after_rst", s_tready, 1);
    @(negedge hdmi_clk);
  endtask

  task automatic check_pix(input string nm, input logic [23:0] rgb, input int x, input int y);
    #1;
    chk({nm, "_valid"}, mon_if.vld, 1);
    chk({nm, "_pix"}, {mon_if.rgb, mon_if.x, mon_if.y}, {rgb, 8'(x), 8'(y)});
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    logic [40:0] e;
    forever begin
      @(negedge hdmi_clk);
      #1;
      if (!rst_n) begin
        exp_fd = 0;
      end else begin
        chk("byte_cnt", byte_cnt, model_cnt);
        chk("frame_done", frame_done, exp_fd);
        if (frame_done) fd_cnt++;
        exp_fd = mon_if.vld && mon_if.rdy && mon_if.last;
        if (mon_if.vld && mon_if.rdy) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL unexpected_pixel: got %0h, expected none", mon_if.rgb);
          end else begin
            e = exp_q.pop_front();
            chk("pixel", {mon_if.rgb, mon_if.x, mon_if.y, mon_if.last}, e);
          end
        end
      end
    end
  end

  // Full-size frame at one byte per cycle.
  initial begin
    int acc = 0, cyc = 0, fd = 0;
    logic [7:0] lx = '0, ly = '0;
    repeat (3) @(negedge hdmi_clk);
    b_rst_n  = 1'b1;
    b_tvalid = 1'b1;
    while (acc < TOTAL_BYTES && cyc < TOTAL_BYTES + 1000) begin
      b_tdata = 8'(cyc);
      #1;
      if (b_tready) acc++;
      if (b_frame_done) fd++;
      if (b_pix_valid && b_last) begin lx = b_x; ly = b_y; end
      cyc++;
      @(negedge hdmi_clk);
    end
    b_tvalid = 1'b0;
    repeat (4) begin
      #1;
      if (b_frame_done) fd++;
      if (b_pix_valid && b_last) begin lx = b_x; ly = b_y; end
      @(negedge hdmi_clk);
    end
    chk("big_bytes", acc, TOTAL_BYTES);
    chk("big_cycles", cyc, TOTAL_BYTES);
    chk("big_frame_done", fd, 1);
    chk("big_last_xy", {lx, ly}, {8'd223, 8'd223});
    chk("big_byte_cnt", b_byte_cnt, 0);
    big_done = 1;
  end

  initial begin
    int w, wsum;
    mon_if.rdy = 1'b1;
    do_reset();

    // Back-to-back stream, output always ready.
    wsum = 0;
    send_byte(8'h11, w); wsum += w;
    send_byte(8'h22, w); wsum += w;
    send_byte(8'h33, w); wsum += w;
    check_pix("p0", 24'h112233, 0, 0);
    send_byte(8'h44, w); wsum += w;
    send_byte(8'h55, w); wsum += w;
    send_byte(8'h66, w); wsum += w;
    check_pix("p1", 24'h445566, 1, 0);
    chk("stream_stalls", wsum, 0);
    idle(3);

    // Output blocked: R/G still flow, B is held off until ready rises.
    mon_if.rdy = 1'b0;
    do_reset();
    send_byte(8'h11, w);
    send_byte(8'h22, w);
    send_byte(8'h33, w);
    wsum = 0;
    send_byte(8'h44, w); wsum += w;
    send_byte(8'h55, w); wsum += w;
    chk("rg_no_stall", wsum, 0);
    s_tdata  = 8'h66;
    s_tvalid = 1'b1;
    #1;
    chk("b_tready_low", s_tready, 0);
    chk("held_pix", {mon_if.vld, mon_if.rgb}, {1'b1, 24'h112233});
    @(negedge hdmi_clk);
    mon_if.rdy = 1'b1;
    send_byte(8'h66, w);
    chk("b_accept_on_ready", w, 0);
    check_pix("p1_after_hold", 24'h445566, 1, 0);
    idle(3);

    // Random gaps over one full 4x2 frame plus the first pixel of the next.
    do_reset();
    rand_rdy = 1;
    for (int i = 0; i < FB + 3; i++) begin
      idle($urandom_range(0, 2));
      send_byte(8'($urandom), w);
    end
    rand_rdy   = 0;
    mon_if.rdy = 1'b1;
    idle(5);
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_frame_done_cnt", fd_cnt, 1);
    chk("rand_pix_count", pix_n, W * H + 1);

    // Reset mid-frame after the G byte of pixel (2,0).
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), w);
    do_reset();
    send_byte(8'hAA, w);
    send_byte(8'hBB, w);
    send_byte(8'hCC, w);
    check_pix("after_midreset", 24'hAABBCC, 0, 0);
    idle(4);
    chk("final_drained", exp_q.size(), 0);

    while (!big_done) @(negedge hdmi_clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_rgb_collector.md
AXIS_RGB_COLLECTOR -- requirements
Module: axis_rgb_collector

Interface
REQ-001 SHALL have parameter WIDTH, default 224: pixels per line, 1..256.
REQ-002 SHALL have parameter HEIGHT, default 224: lines per frame, 1..256.
REQ-003 SHALL have port hdmi_clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port s_axis_0_tdata, input, 8: stream byte in R,G,B order per pixel, raster order.
REQ-006 SHALL have port s_axis_0_tvalid, input, 1: byte valid.
REQ-007 SHALL have port s_axis_0_tready, output, 1: byte accepted when tvalid & tready.
REQ-008 SHALL have port pix_rgb, output, 24: assembled pixel {R,G,B}, R in [23:16].
REQ-009 SHALL have port pix_valid, output, 1: pix_rgb/pix_x/pix_y/pix_last valid.
REQ-010 SHALL have port pix_ready, input, 1: downstream accepts the pixel when pix_valid & pix_ready.
REQ-011 SHALL have port pix_x, output, 8: column of the presented pixel.
REQ-012 SHALL have port pix_y, output, 8: line of the presented pixel.
REQ-013 SHALL have port pix_last, output, 1: presented pixel is (WIDTH-1, HEIGHT-1).
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse on the handshake of the last pixel.
REQ-015 SHALL have port byte_cnt, output, 18: bytes accepted in the current frame.

Function
REQ-016 SHALL implement a phase FSM with states PH_R, PH_G, PH_B; each accepted byte advances PH_R->PH_G->PH_B->PH_R; there are no other transitions.
REQ-017 SHALL latch the byte into the R register in PH_R and the G register in PH_G.
REQ-018 SHALL load {R,G,byte} into the output register in PH_B, together with the current x/y and the last-pixel flag.
REQ-019 SHALL raise pix_valid on the cycle after the B byte is accepted, giving a latency of one cycle.
REQ-020 SHALL hold pix_valid and the payload stable until the pix_valid & pix_ready handshake.
REQ-021 SHALL drive s_axis_0_tready high in PH_R and PH_G regardless of output state.
REQ-022 SHALL drive s_axis_0_tready in PH_B as (!pix_valid | pix_ready).
REQ-023 SHALL, when a pixel is consumed and a B byte is accepted in the same cycle, load the new pixel and keep pix_valid high with no bubble, sustaining 1 byte/cycle.
REQ-024 SHALL advance the x/y counters on each pixel load: x increments; at x==WIDTH-1, x wraps to 0 and y increments; at (WIDTH-1, HEIGHT-1), both wrap to 0.
REQ-025 SHALL increment byte_cnt on every accepted byte.
REQ-026 SHALL wrap byte_cnt to 0 on acceptance of byte number WIDTH*HEIGHT*3-1.
REQ-027 SHALL pulse frame_done high for exactly the cycle after the handshake of the pixel whose pix_last=1.
REQ-028 SHALL NOT change any state or counter on a cycle with s_axis_0_tvalid low; gaps are permitted at any phase.
REQ-029 SHALL NOT let s_axis_0_tready depend combinationally on s_axis_0_tvalid.

Reset
REQ-030 SHALL, when rst_n is low at a rising edge, set the phase to PH_R, x/y to 0, byte_cnt to 0, and the R/G registers to 0.
REQ-031 SHALL, on the same reset, set pix_valid to 0, pix_rgb to 0, pix_x/pix_y to 0, pix_last to 0, and frame_done to 0.
REQ-032 SHALL drive s_axis_0_tready low while rst_n is low.
REQ-033 SHALL drive s_axis_0_tready high on the first cycle after reset is released.
REQ-034 SHALL discard any partial pixel and any pending output pixel on reset mid-frame; the next accepted byte is R of pixel (0,0).

Structure
REQ-035 SHALL take the phase encoding (PH_R=2'd0, PH_G=2'd1, PH_B=2'd2) from the shared package axis_img_pkg.
REQ-036 SHALL take the default WIDTH/HEIGHT and TOTAL_BYTES=WIDTH*HEIGHT*3 from axis_img_pkg, shared with the byte-stream source.
REQ-037 SHALL implement the output register and its ready logic as one sub-module, rgb_out_reg: a single-entry register slice with 24+8+8+1 bits of payload.

Verification
REQ-038 SHALL cover streaming with pix_ready=1 and bytes 0x11,0x22,0x33,0x44,0x55,0x66 back-to-back: pixels 0x112233 at (0,0) then 0x445566 at (1,0), each one cycle after its B byte, and tready constantly high.
REQ-039 SHALL cover holding pix_ready=0 after one complete pixel: tready high for the next R and G bytes, low in PH_B; on raising pix_ready, the B byte is accepted that cycle and the second pixel is presented the next cycle.
REQ-040 SHALL cover a full frame with WIDTH=4, HEIGHT=2 and random tvalid/pix_ready gaps: 8 pixels in raster order and pix_last only on (3,1).
REQ-041 SHALL cover the end of the WIDTH=4, HEIGHT=2 frame: a single frame_done pulse, byte_cnt returning 23->0, and the next pixel at (0,0).
REQ-042 SHALL cover asserting rst_n=0 after the G byte of pixel (2,0): pix_valid=0 and byte_cnt=0 after reset, and bytes 0xAA,0xBB,0xCC then produce 0xAABBCC at (0,0).
REQ-043 SHALL cover a default 224x224 frame at full throughput: 150528 bytes accepted in 150528 cycles and frame_done exactly once, with pix_x=223, pix_y=223 on the last pixel.
